// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and EXE-stage
// misprediction detection. Optional hit/mispredict statistics under BTB_STATS_EN.
module btb_predictor #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] cur_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic            res_taken,
    input  logic [PC_W-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [PC_W-1:0] res_pred_pc,
`ifdef BTB_STATS_EN
    output logic [15:0]     stat_hits,
    output logic [15:0]     stat_mispred,
`endif
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             cur_hit;
    logic             res_hit;
    logic [CNT_W-1:0] cnt_next;

    assign cur_idx = cur_pc[IDX_W-1:0];
    assign cur_tag = cur_pc[PC_W-1:IDX_W];
    assign res_idx = res_pc[IDX_W-1:0];
    assign res_tag = res_pc[PC_W-1:IDX_W];

    assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

    // Gated by rst so outputs are clean even before the first reset edge.
    assign pred_taken = !rst && cur_hit && cnt_q[cur_idx][CNT_W-1];
    assign pred_pc    = pred_taken ? target_q[cur_idx] : cur_pc + PC_ONE;

    assign mispredict  = !rst && res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_pc)));
    assign redirect_pc = res_taken ? res_target : res_pc + PC_ONE;

    always_comb begin
        cnt_next = cnt_q[res_idx];
        if (res_taken) begin
            if (cnt_q[res_idx] != CNT_MAX) cnt_next = cnt_q[res_idx] + 1'b1;
        end else begin
            if (cnt_q[res_idx] != '0) cnt_next = cnt_q[res_idx] - 1'b1;
        end
    end

    // Tags and targets are left stale on reset; a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= '0;
            end
        end else if (res_valid) begin
            if (res_hit) begin
                cnt_q[res_idx] <= cnt_next;
                if (res_taken) target_q[res_idx] <= res_target;
            end else if (res_taken) begin
                valid_q[res_idx]  <= 1'b1;
                tag_q[res_idx]    <= res_tag;
                target_q[res_idx] <= res_target;
                cnt_q[res_idx]    <= CNT_WEAK;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] stat_hits_q;
    logic [15:0] stat_mispred_q;
    logic        good_pred;

    assign good_pred = res_valid && res_pred_taken && !mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (good_pred && stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
            if (mispredict && stat_mispred_q != 16'hFFFF) begin
                stat_mispred_q <= stat_mispred_q + 16'd1;
            end
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed, table-driven bench for btb_predictor (default parameters), with hand
// sequences for counter saturation and, when BTB_STATS_EN is defined, the statistics.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cur_pc;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        res_valid;
    logic [15:0] res_pc;
    logic        res_taken;
    logic [15:0] res_target;
    logic        res_pred_taken;
    logic [15:0] res_pred_pc;
    logic        mispredict;
    logic [15:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btb_predictor #(.ENTRIES(8), .PC_W(16), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .cur_pc         (cur_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_pred_taken (res_pred_taken),
        .res_pred_pc    (res_pred_pc),
`ifdef BTB_STATS_EN
        .stat_hits      (stat_hits),
        .stat_mispred   (stat_mispred),
`endif
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        rst;
        logic [15:0] cur;
        logic        rv;
        logic [15:0] rpc;
        logic        rt;
        logic [15:0] rtgt;
        logic        rpt;
        logic [15:0] rppc;
        logic        e_taken;
        logic [15:0] e_pc;
        logic        e_mis;
        logic [15:0] e_redir;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic r, logic [15:0] c, logic rv, logic [15:0] rpc, logic rt,
                                logic [15:0] rtgt, logic rpt, logic [15:0] rppc, logic et,
                                logic [15:0] epc, logic em, logic [15:0] erd);
        vec_t v;
        v.rst = r;  v.cur = c;  v.rv = rv;  v.rpc = rpc;  v.rt = rt;  v.rtgt = rtgt;
        v.rpt = rpt;  v.rppc = rppc;  v.e_taken = et;  v.e_pc = epc;  v.e_mis = em;
        v.e_redir = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] c, input logic rv,
                         input logic [15:0] rpc, input logic rt, input logic [15:0] rtgt,
                         input logic rpt, input logic [15:0] rppc);
        @(negedge clk);
        rst = r;  cur_pc = c;  res_valid = rv;  res_pc = rpc;  res_taken = rt;
        res_target = rtgt;  res_pred_taken = rpt;  res_pred_pc = rppc;
        #2;
    endtask

    initial begin
        rst = 1'b1;  cur_pc = '0;  res_valid = 1'b0;  res_pc = '0;  res_taken = 1'b0;
        res_target = '0;  res_pred_taken = 1'b0;  res_pred_pc = '0;

        //            rst cur      rv rpc      rt rtgt     rpt rppc     et epc      em redir
        tbl[0]  = mk(1, 16'h0010, 1, 16'h0010, 1, 16'h0099, 0, 16'h0011, 0, 16'h0011, 0, 16'h0);
        tbl[1]  = mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 0, 16'h0);
        tbl[2]  = mk(0, 16'h0010, 1, 16'h0013, 1, 16'h0040, 0, 16'h0014, 0, 16'h0011, 1, 16'h0040);
        tbl[3]  = mk(0, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0);
        tbl[4]  = mk(0, 16'h0013, 1, 16'h0013, 0, 16'h0000, 1, 16'h0040, 1, 16'h0040, 1, 16'h0014);
        tbl[5]  = mk(0, 16'h0013, 1, 16'h0013, 0, 16'h0000, 0, 16'h0014, 0, 16'h0014, 0, 16'h0);
        tbl[6]  = mk(0, 16'h0013, 1, 16'h0013, 0, 16'h0000, 0, 16'h0014, 0, 16'h0014, 0, 16'h0);
        tbl[7]  = mk(0, 16'h0013, 1, 16'h0013, 1, 16'h0040, 0, 16'h0014, 0, 16'h0014, 1, 16'h0040);
        tbl[8]  = mk(0, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0014, 0, 16'h0);
        tbl[9]  = mk(0, 16'h0013, 1, 16'h0013, 1, 16'h0040, 0, 16'h0014, 0, 16'h0014, 1, 16'h0040);
        tbl[10] = mk(0, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0);
        tbl[11] = mk(0, 16'h0013, 1, 16'h001B, 1, 16'h0100, 0, 16'h001C, 1, 16'h0040, 1, 16'h0100);
        tbl[12] = mk(0, 16'h0013, 1, 16'h0013, 1, 16'h0041, 1, 16'h0040, 0, 16'h0014, 1, 16'h0041);
        tbl[13] = mk(0, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 0, 16'h0);
        tbl[14] = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0200, 0, 16'h0006, 0, 16'h0006, 1, 16'h0200);
        tbl[15] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 16'h0);
        tbl[16] = mk(0, 16'hFFFF, 1, 16'h0005, 1, 16'h0200, 1, 16'h0200, 0, 16'h0000, 0, 16'h0);
        tbl[17] = mk(0, 16'h0006, 1, 16'h0006, 0, 16'h0000, 0, 16'h0007, 0, 16'h0007, 0, 16'h0);
        tbl[18] = mk(0, 16'h0006, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0007, 0, 16'h0);
        tbl[19] = mk(0, 16'h0006, 0, 16'h0006, 1, 16'h0300, 0, 16'h0007, 0, 16'h0007, 0, 16'h0);
        tbl[20] = mk(0, 16'h0006, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0007, 0, 16'h0);
        tbl[21] = mk(0, 16'h0005, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h1234, 1, 16'h0200, 1, 16'h0000);
        tbl[22] = mk(0, 16'h0005, 1, 16'h0005, 1, 16'h0210, 1, 16'h0200, 1, 16'h0200, 1, 16'h0210);
        tbl[23] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0210, 0, 16'h0);
        tbl[24] = mk(1, 16'h0005, 1, 16'h0005, 0, 16'h0000, 1, 16'h0210, 0, 16'h0006, 0, 16'h0);
        tbl[25] = mk(0, 16'h0005, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 0, 16'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].cur, tbl[i].rv, tbl[i].rpc, tbl[i].rt, tbl[i].rtgt,
                  tbl[i].rpt, tbl[i].rppc);
            check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(tbl[i].e_taken));
            check($sformatf("v%0d pred_pc", i), 32'(pred_pc), 32'(tbl[i].e_pc));
            check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
            if (tbl[i].e_mis) begin
                check($sformatf("v%0d redirect_pc", i), 32'(redirect_pc), 32'(tbl[i].e_redir));
            end
        end

        // Upper saturation: three taken resolutions keep the counter at 3,
        // so one not-taken still predicts taken and a second does not.
        drive(1, 16'h0020, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        drive(0, 16'h0020, 1, 16'h0020, 1, 16'h0050, 0, 16'h0021);
        for (int k = 0; k < 3; k++) drive(0, 16'h0020, 1, 16'h0020, 1, 16'h0050, 1, 16'h0050);
        drive(0, 16'h0020, 1, 16'h0020, 0, 16'h0, 1, 16'h0050);
        drive(0, 16'h0020, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        check("sat one not-taken pred_taken", 32'(pred_taken), 32'd1);
        drive(0, 16'h0020, 1, 16'h0020, 0, 16'h0, 1, 16'h0050);
        drive(0, 16'h0020, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        check("sat two not-taken pred_taken", 32'(pred_taken), 32'd0);
        check("sat two not-taken pred_pc", 32'(pred_pc), 32'h0021);

`ifdef BTB_STATS_EN
        drive(1, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        check("stat_hits after rst", 32'(stat_hits), 32'd0);
        check("stat_mispred after rst", 32'(stat_mispred), 32'd0);
        drive(0, 16'h0, 1, 16'h0030, 1, 16'h0060, 0, 16'h0031);
        for (int k = 0; k < 3; k++) drive(0, 16'h0, 1, 16'h0030, 1, 16'h0060, 1, 16'h0060);
        drive(0, 16'h0, 1, 16'h0030, 0, 16'h0, 1, 16'h0060);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        check("stat_hits", 32'(stat_hits), 32'd3);
        check("stat_mispred", 32'(stat_mispred), 32'd2);
        drive(1, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        check("stat_hits cleared", 32'(stat_hits), 32'd0);
        check("stat_mispred cleared", 32'(stat_mispred), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
